// File: rtl/mbist_pkg.sv
// March C- definitions shared by the BIST controller and its helpers:
// element and op encodings, the FSM state type and the constant march table.
package mbist_pkg;

    localparam int NUM_ELEMS = 6;

    typedef enum logic [2:0] {
        ELEM_E0 = 3'd0,
        ELEM_E1 = 3'd1,
        ELEM_E2 = 3'd2,
        ELEM_E3 = 3'd3,
        ELEM_E4 = 3'd4,
        ELEM_E5 = 3'd5
    } elem_t;

    typedef enum logic [1:0] {
        OP_R0 = 2'd0,
        OP_R1 = 2'd1,
        OP_W0 = 2'd2,
        OP_W1 = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One march element: address direction, number of ops and the op list.
    typedef struct packed {
        logic       dir_up;
        logic [1:0] op_len;
        op_t        op0;
        op_t        op1;
    } elem_desc_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic elem_desc_t march_table(input elem_t e);
        elem_desc_t d;
        case (e)
            ELEM_E0: d = '{dir_up: 1'b1, op_len: 2'd1, op0: OP_W0, op1: OP_W0};
            ELEM_E1: d = '{dir_up: 1'b1, op_len: 2'd2, op0: OP_R0, op1: OP_W1};
            ELEM_E2: d = '{dir_up: 1'b1, op_len: 2'd2, op0: OP_R1, op1: OP_W0};
            ELEM_E3: d = '{dir_up: 1'b0, op_len: 2'd2, op0: OP_R0, op1: OP_W1};
            ELEM_E4: d = '{dir_up: 1'b0, op_len: 2'd2, op0: OP_R1, op1: OP_W0};
            default: d = '{dir_up: 1'b1, op_len: 2'd1, op0: OP_R0, op1: OP_R0};
        endcase
        return d;
    endfunction

    function automatic logic op_is_write(input op_t op);
        return (op == OP_W0) || (op == OP_W1);
    endfunction

    // Data polarity of an op: 1 for r1/w1, 0 for r0/w0.
    function automatic logic op_value(input op_t op);
        return (op == OP_R1) || (op == OP_W1);
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter for the march sequencer. last_addr flags
// the final address of the current direction (all-ones going up, zero going down).
module mbist_addr_gen #(
    parameter int address_bits = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [address_bits-1:0] load_val,
    input  logic                    step,
    input  logic                    up,
    output logic [address_bits-1:0] addr,
    output logic                    last_addr
);

    logic [address_bits-1:0] addr_reg;

    // Address register: load wins over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
        end else if (load) begin
            addr_reg <= load_val;
        end else if (step) begin
            addr_reg <= up ? addr_reg + 1'b1 : addr_reg - 1'b1;
        end
    end

    assign addr      = addr_reg;
    assign last_addr = up ? (&addr_reg) : ~(|addr_reg);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller. Issues one memory op per RUN cycle from an
// op pointer that always points at the next op to issue, waits RD_LAT cycles
// after each read, compares data_r and records the first miscompare.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int word_size    = 8,
    parameter int address_bits = 4,
    parameter int RD_LAT       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [7:0]              err_cnt,
    output logic [2:0]              fail_elem,
    output logic [address_bits-1:0] fail_addr,
    output logic [word_size-1:0]    fail_exp,
    output logic [word_size-1:0]    fail_act,
    output logic                    mem_enable,
    output logic                    mem_RW,
    output logic [address_bits-1:0] mem_add,
    output logic [word_size-1:0]    mem_data_w,
    input  logic [word_size-1:0]    mem_data_r
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(RD_LAT - 1);
    localparam logic [address_bits-1:0] ADDR_MAX = {address_bits{1'b1}};

    state_t state_reg, state_next;

    // Op pointer: element, op index within element, address, and end flag.
    elem_t                   ptr_elem_reg;
    logic                    ptr_op_reg;
    logic                    ptr_end_reg;
    logic [address_bits-1:0] ptr_addr;
    logic                    ptr_last_addr;
    elem_desc_t              ptr_desc;
    op_t                     ptr_op;
    logic                    ptr_op_more;
    elem_t                   elem_next;

    logic                    ag_load, ag_step;
    logic [address_bits-1:0] ag_load_val;

    logic                    issue;
    logic                    busy_next, done_next;
    logic [WCW-1:0]          wait_cnt_reg;
    logic                    wait_last;
    logic                    cmp_fire;

    logic                    busy_reg, done_reg, mem_enable_reg, mem_rw_reg;
    logic [address_bits-1:0] mem_add_reg;
    logic [word_size-1:0]    mem_data_w_reg;
    logic [word_size-1:0]    exp_reg;
    elem_t                   rd_elem_reg;

    logic                    fail_reg;
    logic [7:0]              err_cnt_reg;
    logic [2:0]              fail_elem_reg;
    logic [address_bits-1:0] fail_addr_reg;
    logic [word_size-1:0]    fail_exp_reg, fail_act_reg;

    assign ptr_desc    = march_table(ptr_elem_reg);
    assign ptr_op      = ptr_op_reg ? ptr_desc.op1 : ptr_desc.op0;
    assign ptr_op_more = !ptr_op_reg && (ptr_desc.op_len == 2'd2);
    assign elem_next   = elem_t'(ptr_elem_reg + 3'd1);
    assign wait_last   = (wait_cnt_reg == WAIT_LAST);
    assign cmp_fire    = (state_reg == ST_WAIT) && wait_last;

    mbist_addr_gen #(
        .address_bits(address_bits)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ag_load),
        .load_val (ag_load_val),
        .step     (ag_step),
        .up       (ptr_desc.dir_up),
        .addr     (ptr_addr),
        .last_addr(ptr_last_addr)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state: writes chain straight into the next op, reads detour via WAIT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (!mem_rw_reg)      state_next = ST_WAIT;
                else if (ptr_end_reg) state_next = ST_DONE;
                else                  state_next = ST_RUN;
            end
            ST_WAIT: begin
                if (wait_last) state_next = ptr_end_reg ? ST_DONE : ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered status and command strobes.
    always_comb begin
        issue     = (state_next == ST_RUN);
        busy_next = (state_next == ST_RUN) || (state_next == ST_WAIT);
        done_next = (state_next == ST_DONE);
    end

    // Address generator control: step within an element, reload on element change, rewind after a run.
    always_comb begin
        ag_load     = 1'b0;
        ag_step     = 1'b0;
        ag_load_val = '0;
        if (state_reg == ST_DONE) begin
            ag_load = 1'b1;
        end else if (issue && !ptr_op_more) begin
            if (!ptr_last_addr) begin
                ag_step = 1'b1;
            end else if (ptr_elem_reg != ELEM_E5) begin
                ag_load     = 1'b1;
                ag_load_val = march_table(elem_next).dir_up ? '0 : ADDR_MAX;
            end
        end
    end

    // Op pointer advance on every issued op; rewound to E0 after the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_elem_reg <= ELEM_E0;
            ptr_op_reg   <= 1'b0;
            ptr_end_reg  <= 1'b0;
        end else if (state_reg == ST_DONE) begin
            ptr_elem_reg <= ELEM_E0;
            ptr_op_reg   <= 1'b0;
            ptr_end_reg  <= 1'b0;
        end else if (issue) begin
            if (ptr_op_more) begin
                ptr_op_reg <= 1'b1;
            end else begin
                ptr_op_reg <= 1'b0;
                if (ptr_last_addr) begin
                    if (ptr_elem_reg == ELEM_E5) ptr_end_reg  <= 1'b1;
                    else                         ptr_elem_reg <= elem_next;
                end
            end
        end
    end

    // Registered memory command and status; command fields hold outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            mem_enable_reg <= 1'b0;
            mem_rw_reg     <= 1'b0;
            mem_add_reg    <= '0;
            mem_data_w_reg <= '0;
            exp_reg        <= '0;
            rd_elem_reg    <= ELEM_E0;
        end else begin
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            mem_enable_reg <= issue;
            if (issue) begin
                mem_rw_reg  <= op_is_write(ptr_op);
                mem_add_reg <= ptr_addr;
                if (op_is_write(ptr_op)) begin
                    mem_data_w_reg <= {word_size{op_value(ptr_op)}};
                end else begin
                    exp_reg     <= {word_size{op_value(ptr_op)}};
                    rd_elem_reg <= ptr_elem_reg;
                end
            end
        end
    end

    // Read latency counter, restarted on each entry into WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT && !wait_last) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    // Result capture: cleared on start, first miscompare latched, error count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_reg      <= 1'b0;
            err_cnt_reg   <= '0;
            fail_elem_reg <= '0;
            fail_addr_reg <= '0;
            fail_exp_reg  <= '0;
            fail_act_reg  <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            fail_reg      <= 1'b0;
            err_cnt_reg   <= '0;
            fail_elem_reg <= '0;
            fail_addr_reg <= '0;
            fail_exp_reg  <= '0;
            fail_act_reg  <= '0;
        end else if (cmp_fire && (mem_data_r != exp_reg)) begin
            fail_reg <= 1'b1;
            if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
            if (!fail_reg) begin
                fail_elem_reg <= rd_elem_reg;
                fail_addr_reg <= mem_add_reg;
                fail_exp_reg  <= exp_reg;
                fail_act_reg  <= mem_data_r;
            end
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign fail       = fail_reg;
    assign err_cnt    = err_cnt_reg;
    assign fail_elem  = fail_elem_reg;
    assign fail_addr  = fail_addr_reg;
    assign fail_exp   = fail_exp_reg;
    assign fail_act   = fail_act_reg;
    assign mem_enable = mem_enable_reg;
    assign mem_RW     = mem_rw_reg;
    assign mem_add    = mem_add_reg;
    assign mem_data_w = mem_data_w_reg;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench: mbist_march_ctrl driving a 16x8 memory model with
// read-data fault injection, plus restart-while-busy and async reset cases.
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, fail;
    logic [7:0] err_cnt;
    logic [2:0] fail_elem;
    logic [3:0] fail_addr;
    logic [7:0] fail_exp, fail_act;
    logic       mem_enable, mem_RW;
    logic [3:0] mem_add;
    logic [7:0] mem_data_w, mem_data_r;

    // Memory model: one-cycle read latency.
    logic [7:0] mem_arr [16];
    logic [7:0] mem_q = 8'h00;
    logic [3:0] rd_add_q = 4'h0;
    int         fault_mode = 0;   // 0 none, 1 bit3 stuck-at-1 at addr 5, 2 data_r stuck at FF

    int n_checks = 0;
    int n_pass   = 0;

    int busy_cyc, done_cyc, done_idx, en_cyc, wr_cyc;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_RW) begin
                mem_arr[mem_add] <= mem_data_w;
            end else begin
                mem_q    <= mem_arr[mem_add];
                rd_add_q <= mem_add;
            end
        end
    end

    always_comb begin
        mem_data_r = mem_q;
        if (fault_mode == 1 && rd_add_q == 4'd5) mem_data_r = mem_q | 8'h08;
        else if (fault_mode == 2)                mem_data_r = 8'hFF;
    end

    mbist_march_ctrl #(
        .word_size   (8),
        .address_bits(4),
        .RD_LAT      (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .err_cnt   (err_cnt),
        .fail_elem (fail_elem),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act),
        .mem_enable(mem_enable),
        .mem_RW    (mem_RW),
        .mem_add   (mem_add),
        .mem_data_w(mem_data_w),
        .mem_data_r(mem_data_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pulse start, then watch 260 cycles; optionally pulse start again at cycle restart_at.
    task automatic run_march(input int restart_at);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0; done_cyc = 0; done_idx = -1; en_cyc = 0; wr_cyc = 0;
        for (int i = 0; i < 260; i++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc++;
                done_idx = i;
            end
            if (mem_enable) en_cyc++;
            if (mem_enable && mem_RW) wr_cyc++;
            start = (i == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        $display("run: busy=%0d done=%0d@%0d en=%0d wr=%0d fail=%0b err=%0d elem=%0d addr=%0d exp=%02h act=%02h",
                 busy_cyc, done_cyc, done_idx, en_cyc, wr_cyc, fail, err_cnt, fail_elem, fail_addr, fail_exp, fail_act);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_mem_enable", 32'(mem_enable), 32'd0);
        chk("rst_fail_addr", 32'(fail_addr), 32'd0);
        #9 rst_n = 1'b1;

        // 1. Fault-free run
        run_march(-1);
        chk("s1_busy_cycles", 32'(busy_cyc), 32'd240);
        chk("s1_done_pulses", 32'(done_cyc), 32'd1);
        chk("s1_done_index", 32'(done_idx), 32'd240);
        chk("s1_enable_cycles", 32'(en_cyc), 32'd160);
        chk("s1_write_cycles", 32'(wr_cyc), 32'd80);
        chk("s1_fail", 32'(fail), 32'd0);
        chk("s1_err_cnt", 32'(err_cnt), 32'd0);
        chk("s1_mem0_final", 32'(mem_arr[0]), 32'h00);
        chk("s1_mem15_final", 32'(mem_arr[15]), 32'h00);

        // 2. Bit 3 stuck-at-1 at address 5: r0 reads in E1, E3, E5 miscompare
        fault_mode = 1;
        run_march(-1);
        chk("s2_busy_cycles", 32'(busy_cyc), 32'd240);
        chk("s2_fail", 32'(fail), 32'd1);
        chk("s2_err_cnt", 32'(err_cnt), 32'd3);
        chk("s2_fail_elem", 32'(fail_elem), 32'd1);
        chk("s2_fail_addr", 32'(fail_addr), 32'd5);
        chk("s2_fail_exp", 32'(fail_exp), 32'h00);
        chk("s2_fail_act", 32'(fail_act), 32'h08);

        // 3. data_r stuck at FF: every r0 (3 elements x 16) miscompares
        fault_mode = 2;
        run_march(-1);
        chk("s3_err_cnt", 32'(err_cnt), 32'd48);
        chk("s3_fail_elem", 32'(fail_elem), 32'd1);
        chk("s3_fail_addr", 32'(fail_addr), 32'd0);
        chk("s3_fail_exp", 32'(fail_exp), 32'h00);
        chk("s3_fail_act", 32'(fail_act), 32'hFF);

        // 6. Clean run after a failing one clears all results
        fault_mode = 0;
        run_march(-1);
        chk("s6_fail", 32'(fail), 32'd0);
        chk("s6_err_cnt", 32'(err_cnt), 32'd0);
        chk("s6_fail_elem", 32'(fail_elem), 32'd0);
        chk("s6_fail_addr", 32'(fail_addr), 32'd0);
        chk("s6_fail_act", 32'(fail_act), 32'h00);

        // 4. Start pulsed while busy is ignored
        run_march(100);
        chk("s4_busy_cycles", 32'(busy_cyc), 32'd240);
        chk("s4_done_pulses", 32'(done_cyc), 32'd1);
        chk("s4_done_index", 32'(done_idx), 32'd240);

        // 5. Asynchronous reset mid-run
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("s5_busy_before_rst", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_enable_async", 32'(mem_enable), 32'd0);
        chk("s5_busy_async", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("s5_no_resume", 32'(busy), 32'd0);
        run_march(-1);
        chk("s5_busy_cycles", 32'(busy_cyc), 32'd240);
        chk("s5_done_pulses", 32'(done_cyc), 32'd1);
        chk("s5_fail", 32'(fail), 32'd0);
        chk("s5_err_cnt", 32'(err_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
